// File: rtl/mux_pkg.sv
// Shared types and constants for the mux select sequencer.
// Holds the FSM state encoding, mux geometry and a select-to-one-hot helper.
package mux_pkg;

    localparam int MUX_N = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_e;

    function automatic logic [MUX_N-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        return MUX_N'(1) << sel;
    endfunction

endpackage

// File: rtl/mux_4x1.sv
// Plain combinational 4:1 mux; {S1,S0} selects one of i0..i3 onto Y.
module mux_4x1 #(
    parameter int W = 8
) (
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    input  logic         S1,
    input  logic         S0,
    output logic [W-1:0] Y
);

    always_comb begin
        unique case ({S1, S0})
            2'd0:    Y = i0;
            2'd1:    Y = i1;
            2'd2:    Y = i2;
            default: Y = i3;
        endcase
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick among four requests, searching upward from ptr
// and wrapping 3->0; reports the winning index and whether anything requested.
module rr_arbiter4
    import mux_pkg::*;
(
    input  logic [MUX_N-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    logic [SEL_W-1:0] idx;

    // NOTE: every signal written in always_comb gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        // Walk from the farthest offset down to ptr itself: the last hit written
        // is the one closest to ptr, which is the round-robin winner.
        for (int i = MUX_N - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin select generator for mux_4x1: grants one channel for HOLD_BEATS
// accepted beats (or until its request drops) and qualifies Y with valid/ready.
module mux_sel_sequencer
    import mux_pkg::*;
#(
    parameter int HOLD_BEATS = 4,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MUX_N-1:0] req,
    input  logic             out_ready,
    output logic             S1,
    output logic             S0,
    output logic [MUX_N-1:0] gnt,
    output logic             out_valid,
    output logic             beat,
    output logic             last
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [MUX_N-1:0] gnt_q, gnt_d;
    logic             out_valid_q, out_valid_d;

    logic [SEL_W-1:0] arb_ptr;
    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             granted_req;
    logic             cnt_zero;
    logic             release_grant;

    // gnt_q is zero in IDLE, so this is also 0 whenever no grant is held.
    assign granted_req   = |(req & gnt_q);
    assign cnt_zero      = (cnt_q == '0);
    assign beat          = out_valid_q & out_ready & granted_req;
    assign last          = out_valid_q & cnt_zero & granted_req;
    assign release_grant = out_valid_q & (~granted_req | (beat & cnt_zero));

    // On a release edge the new arbitration already uses the advanced pointer.
    assign arb_ptr = (state_q == ST_GRANT) ? sel_q + SEL_W'(1) : ptr_q;

    rr_arbiter4 u_arb (
        .req     (req),
        .ptr     (arb_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d     = ST_GRANT;
                    sel_d       = winner;
                    gnt_d       = sel_to_onehot(winner);
                    cnt_d       = CNT_W'(HOLD_BEATS - 1);
                    out_valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (release_grant) begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (any_req) begin
                        sel_d = winner;
                        gnt_d = sel_to_onehot(winner);
                        cnt_d = CNT_W'(HOLD_BEATS - 1);
                    end else begin
                        // Selects deliberately keep their last value in IDLE.
                        state_d     = ST_IDLE;
                        gnt_d       = '0;
                        out_valid_d = 1'b0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            sel_q       <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign S1        = sel_q[1];
    assign S0        = sel_q[0];
    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;

endmodule
